// File: rtl/mlp_pkg.sv
`default_nettype none
// mlp_pkg: FSM encoding, accumulator sizing and saturation bounds shared by the dense-layer blocks.
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Headroom: 2W product bits, log2(N_IN) for the sum, one more for the folded-in bias.
  function automatic int acc_width(input int w, input int n_in);
    return 2 * w + $clog2(n_in) + 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dense_mac.sv
`default_nettype none
// dense_mac: registered signed multiply feeding an accumulator; on a neuron's last product it adds
// the bias, rescales with a flooring shift, saturates and optionally applies ReLU.
module dense_mac
  import mlp_pkg::*;
#(
  parameter int INTEGRAL_WIDTH = 4,
  parameter int FRACTION_WIDTH = 16,
  parameter int N_IN           = 5,
  parameter int ACT            = 0,
  localparam int W             = INTEGRAL_WIDTH + FRACTION_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                mul_en,
  input  logic                last,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] bias,
  output logic                fin_valid,
  output logic signed [W-1:0] fin_data
);

  localparam int PW = 2 * W;
  localparam int AW = acc_width(W, N_IN);
  localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(W));
  localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(W));

  logic signed [PW-1:0] x_ext, w_ext, prod;
  logic signed [W-1:0]  prod_bias;
  logic                 prod_valid, prod_last;
  logic signed [AW-1:0] acc, sum, scaled, clamped;

  assign x_ext = PW'(x);
  assign w_ext = PW'(w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_bias  <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      acc        <= '0;
    end else if (clear) begin
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      acc        <= '0;
    end else begin
      prod_valid <= mul_en;
      if (mul_en) begin
        prod      <= x_ext * w_ext;
        prod_last <= last;
        prod_bias <= bias;
      end
      if (prod_valid) acc <= prod_last ? '0 : acc + AW'(prod);
    end
  end

  // Bias is aligned to the product's 2*FRACTION_WIDTH scale before the single rescale.
  always_comb begin
    sum    = acc + AW'(prod) + (AW'(prod_bias) <<< FRACTION_WIDTH);
    scaled = sum >>> FRACTION_WIDTH;
    if (scaled > SAT_HI)      clamped = SAT_HI;
    else if (scaled < SAT_LO) clamped = SAT_LO;
    else                      clamped = scaled;
    if (ACT == 1 && clamped[AW-1]) clamped = '0;
  end

  assign fin_valid = prod_valid & prod_last;
  assign fin_data  = clamped[W-1:0];

endmodule
`default_nettype wire

// File: rtl/dense_layer_seq.sv
`default_nettype none
// dense_layer_seq: sequential fully-connected layer, one multiply per cycle, valid/ready on both sides.
module dense_layer_seq
  import mlp_pkg::*;
#(
  parameter int INTEGRAL_WIDTH = 4,
  parameter int FRACTION_WIDTH = 16,
  parameter int N_IN           = 5,
  parameter int N_OUT          = 3,
  parameter int ACT            = 0,
  parameter logic [N_OUT*N_IN*(INTEGRAL_WIDTH+FRACTION_WIDTH)-1:0] WEIGHTS = '0,
  parameter logic [N_OUT*(INTEGRAL_WIDTH+FRACTION_WIDTH)-1:0]      BIASES  = '0,
  localparam int W = INTEGRAL_WIDTH + FRACTION_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic               busy
);

  localparam int CNT_I_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int CNT_O_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t               state;
  logic [CNT_I_W-1:0]   i_cnt;
  logic [CNT_O_W-1:0]   o_cnt, o_pipe;
  logic                 issuing;
  logic [N_IN*W-1:0]    x_vec;
  logic                 clear, mul_en, last, fin_valid;
  logic signed [W-1:0]  x_sel, w_sel, b_sel, fin_data;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  assign clear  = in_ready && in_valid;
  assign mul_en = (state == ST_MAC) && issuing;
  assign last   = (i_cnt == CNT_I_W'(N_IN - 1));
  assign x_sel  = x_vec[i_cnt*W +: W];
  assign w_sel  = WEIGHTS[(o_cnt*N_IN + i_cnt)*W +: W];
  assign b_sel  = BIASES[o_cnt*W +: W];

  dense_mac #(
    .INTEGRAL_WIDTH (INTEGRAL_WIDTH),
    .FRACTION_WIDTH (FRACTION_WIDTH),
    .N_IN           (N_IN),
    .ACT            (ACT)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mul_en    (mul_en),
    .last      (last),
    .x         (x_sel),
    .w         (w_sel),
    .bias      (b_sel),
    .fin_valid (fin_valid),
    .fin_data  (fin_data)
  );

  // Issue runs one cycle ahead of the accumulate stage, so o_pipe tags the neuron being finalised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      i_cnt    <= '0;
      o_cnt    <= '0;
      o_pipe   <= '0;
      issuing  <= 1'b0;
      x_vec    <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_vec   <= in_data;
            i_cnt   <= '0;
            o_cnt   <= '0;
            issuing <= 1'b1;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (issuing) begin
            o_pipe <= o_cnt;
            if (last) begin
              i_cnt <= '0;
              if (o_cnt == CNT_O_W'(N_OUT - 1)) issuing <= 1'b0;
              else                              o_cnt   <= o_cnt + 1'b1;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
          if (fin_valid) begin
            out_data[o_pipe*W +: W] <= fin_data;
            if (o_pipe == CNT_O_W'(N_OUT - 1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_seq.sv
`default_nettype none
// tb_dense_layer_seq: random and directed vectors through identity and ReLU layers, scoreboarded
// against an arithmetic reference model.
module tb_dense_layer_seq;

  localparam int IW    = 4;
  localparam int FW    = 16;
  localparam int W     = IW + FW;
  localparam int N_IN  = 5;
  localparam int N_OUT = 3;
  localparam int LAT   = N_IN * N_OUT + 1;

  // Row 0: +0.5 each, row 1: -1.0 each, row 2: mixed; bias 0.75 on neuron 2 only.
  localparam logic [N_OUT*N_IN*W-1:0] WTS = {
    20'h00001, 20'hFC000, 20'h18000, 20'hF8000, 20'h04000,
    20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000, 20'hF0000,
    20'h08000, 20'h08000, 20'h08000, 20'h08000, 20'h08000};
  localparam logic [N_OUT*W-1:0] BIS = {20'h0C000, 20'h00000, 20'h00000};

  logic               clk, rst_n;
  logic               in_valid, out_ready;
  logic [N_IN*W-1:0]  in_data;
  logic               in_ready, out_valid, busy;
  logic               r_in_ready, r_out_valid, r_busy;
  logic [N_OUT*W-1:0] out_data, r_out_data;

  dense_layer_seq #(.INTEGRAL_WIDTH(IW), .FRACTION_WIDTH(FW), .N_IN(N_IN), .N_OUT(N_OUT),
                    .ACT(0), .WEIGHTS(WTS), .BIASES(BIS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  dense_layer_seq #(.INTEGRAL_WIDTH(IW), .FRACTION_WIDTH(FW), .N_IN(N_IN), .N_OUT(N_OUT),
                    .ACT(1), .WEIGHTS(WTS), .BIASES(BIS)) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .busy(r_busy));

  typedef struct {
    logic [N_OUT*W-1:0] lin;
    logic [N_OUT*W-1:0] relu;
    int                 acc_cyc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0, checks = 0, cyc = 0;
  bit   prev_valid = 0, rand_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom % 2) == 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    longint r;
    r = longint'(v);
    if (v[W-1]) r = r - (longint'(1) <<< W);
    return r;
  endfunction

  // y_o = clamp(floor((sum_i x_i*w_oi + b_o*2^F) / 2^F)), then optional ReLU.
  function automatic logic [N_OUT*W-1:0] model(input logic [N_IN*W-1:0] v, input bit relu);
    logic [N_OUT*N_IN*W-1:0] wt;
    logic [N_OUT*W-1:0]      bs, r;
    longint                  s, y;
    wt = WTS;
    bs = BIS;
    r  = '0;
    for (int o = 0; o < N_OUT; o++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += sx(v[i*W +: W]) * sx(wt[(o*N_IN+i)*W +: W]);
      s += sx(bs[o*W +: W]) * (longint'(1) <<< FW);
      y = s >>> FW;
      if (y > (longint'(1) <<< (W-1)) - 1) y = (longint'(1) <<< (W-1)) - 1;
      if (y < -(longint'(1) <<< (W-1)))    y = -(longint'(1) <<< (W-1));
      if (relu && y < 0) y = 0;
      r[o*W +: W] = y[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N_IN*W-1:0] rand_vec(input int kind);
    logic [N_IN*W-1:0] v;
    logic [W-1:0]      e;
    int                t;
    for (int i = 0; i < N_IN; i++) begin
      case (kind)
        0: e = W'($urandom);
        1: begin t = $urandom_range(0, 262143) - 131072; e = t[W-1:0]; end
        2: e = 20'h10000;
        default: e = 20'h70000;
      endcase
      v[i*W +: W] = e;
    end
    return v;
  endfunction

  // Scoreboard monitor: compares every cycle a result is presented, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - q[0].acc_cyc), 64'(LAT));
          check("out_data", 64'(out_data), 64'(q[0].lin));
          check("relu_out_data", 64'(r_out_data), 64'(q[0].relu));
          check("relu_out_valid", 64'(r_out_valid), 64'd1);
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          check("busy_in_done", 64'(busy), 64'd1);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [N_IN*W-1:0] v);
    bit   ok, rdy;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 400 && !ok; k++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    if (ok) begin
      e.lin     = model(v, 1'b0);
      e.relu    = model(v, 1'b1);
      e.acc_cyc = cyc;
      q.push_back(e);
      vectors++;
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 3 * LAT && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    if (!out_valid) check(name, 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 4000 && q.size() != 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit inputs: 5 x 0.5 = 2.5 on neuron 0, -5.0 on neuron 1 (ReLU clamps to 0).
    send(rand_vec(2));
    wait_valid("valid_timeout_unit");
    check("unit_n0", 64'(out_data[0 +: W]), 64'h28000);
    check("unit_n1", 64'(out_data[W +: W]), 64'hB0000);
    check("unit_relu_n1", 64'(r_out_data[W +: W]), 64'h00000);
    drain();
    // Inputs of 7.0 drive both saturation rails.
    send(rand_vec(3));
    wait_valid("valid_timeout_sat");
    check("sat_hi_n0", 64'(out_data[0 +: W]), 64'h7FFFF);
    check("sat_lo_n1", 64'(out_data[W +: W]), 64'h80000);
    drain();

    // Consumer stalls in DONE while input pulses must be ignored.
    out_ready = 1'b0;
    send(rand_vec(1));
    wait_valid("valid_timeout_hold");
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_data  = rand_vec(0);
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);

    // Reset in the middle of MAC aborts the vector.
    send(rand_vec(1));
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_relu_busy", 64'(r_busy), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    send(rand_vec(1));
    drain();

    // Random vectors under a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) send(rand_vec(n % 2));
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // Back-to-back with the consumer always ready.
    for (int n = 0; n < 8; n++) send(rand_vec(n % 2));
    drain();
    check("final_relu_in_ready", 64'(r_in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
